// File: rtl/random_multi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : random_pkg
// Brief    : Shared types and helpers for the multi-channel random server.
// Revision : 1.0 - initial release
// ============================================================================
package random_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Right-shifting Galois masks for maximal-length sequences (bit k-1 set for term x^k).
    function automatic logic [31:0] tap_mask(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0007_2000;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic int ch_idx_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/random_multi_lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_core
// Brief    : Free-running Galois LFSR with key-press entropy mixing and zero guard.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_core
    import random_pkg::*;
#(
    parameter int                   LFSR_BITS = 16,
    parameter logic [LFSR_BITS-1:0] SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 entropy_rise,
    output logic [LFSR_BITS-1:0] lfsr
);

    localparam logic [31:0]          c_TAP_FULL = tap_mask(LFSR_BITS);
    localparam logic [LFSR_BITS-1:0] c_TAP_MASK = c_TAP_FULL[LFSR_BITS-1:0];

    logic [LFSR_BITS-1:0] r_lfsr;
    logic [LFSR_BITS-1:0] r_cnt;
    logic                 r_entropy_d;
    logic [LFSR_BITS-1:0] w_step;
    logic [LFSR_BITS-1:0] w_mix;
    logic                 w_rise;

    always_comb begin
        w_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_TAP_MASK) : (r_lfsr >> 1);
        w_rise = entropy_rise & ~r_entropy_d;
        w_mix  = w_rise ? (w_step ^ r_cnt) : w_step;
    end

    // An all-zero state would lock the register, so it is replaced by the seed.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lfsr      <= SEED;
            r_cnt       <= '0;
            r_entropy_d <= 1'b0;
        end else begin
            r_lfsr      <= (w_mix == '0) ? SEED : w_mix;
            r_cnt       <= r_cnt + 1'b1;
            r_entropy_d <= entropy_rise;
        end
    end

    assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/random_multi.sv
`default_nettype none
// ============================================================================
// Module   : random_multi
// Brief    : Round-robin multi-channel random-number server with range reduction.
// Revision : 1.0 - initial release
// ============================================================================
module random_multi
    import random_pkg::*;
#(
    parameter int                   LFSR_BITS = 16,
    parameter int                   OUT_BITS  = 11,
    parameter int                   N_CH      = 4,
    parameter int                   MIN_VAL   = 0,
    parameter int                   MAX_VAL   = 255,
    parameter logic [LFSR_BITS-1:0] SEED      = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     entropy_rise,
    input  logic [N_CH-1:0]          req,
    output logic [N_CH-1:0]          valid,
    output logic [N_CH*OUT_BITS-1:0] dout,
    output logic                     busy
);

    localparam int c_CH_W    = ch_idx_width(N_CH);
    localparam int c_BIT_W   = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam int c_RANGE_I = MAX_VAL - MIN_VAL + 1;
    localparam int c_MID_I   = (MIN_VAL + MAX_VAL) / 2;
    localparam int c_LAST_I  = N_CH - 1;
    localparam int c_TOP_I   = OUT_BITS - 1;

    localparam logic [OUT_BITS:0]     c_RANGE   = c_RANGE_I[OUT_BITS:0];
    localparam logic [OUT_BITS-1:0]   c_MIN     = MIN_VAL[OUT_BITS-1:0];
    localparam logic [OUT_BITS-1:0]   c_MID     = c_MID_I[OUT_BITS-1:0];
    localparam logic [c_CH_W:0]       c_NCH     = N_CH[c_CH_W:0];
    localparam logic [c_CH_W-1:0]     c_LAST    = c_LAST_I[c_CH_W-1:0];
    localparam logic [c_BIT_W-1:0]    c_BIT_TOP = c_TOP_I[c_BIT_W-1:0];

    logic [LFSR_BITS-1:0]     w_lfsr;
    logic                     w_lfsr_unused;
    state_t                   r_state;
    logic [c_CH_W-1:0]        r_ch;
    logic [c_CH_W-1:0]        r_rr;
    logic [OUT_BITS-1:0]      r_work;
    logic [OUT_BITS-1:0]      r_rem;
    logic [c_BIT_W-1:0]       r_bit;
    logic [N_CH-1:0]          r_valid;
    logic [N_CH*OUT_BITS-1:0] r_dout;
    logic                     r_busy;

    logic                     w_grant_ok;
    logic [c_CH_W-1:0]        w_grant_ch;
    logic [c_CH_W:0]          w_idx;
    logic [OUT_BITS:0]        w_shift;
    logic [OUT_BITS:0]        w_sub;
    logic [OUT_BITS-1:0]      w_rem_next;
    logic [OUT_BITS-1:0]      w_result;
    logic [c_CH_W-1:0]        w_rr_next;

    lfsr_core #(
        .LFSR_BITS (LFSR_BITS),
        .SEED      (SEED)
    ) u_lfsr (
        .clk          (clk),
        .resetN       (resetN),
        .entropy_rise (entropy_rise),
        .lfsr         (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr;

    // Scan from the farthest offset down so the nearest requester at/after r_rr wins.
    always_comb begin
        w_grant_ok = 1'b0;
        w_grant_ch = '0;
        w_idx      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr} + (c_CH_W + 1)'(i);
            if (w_idx >= c_NCH) begin
                w_idx = w_idx - c_NCH;
            end
            if (req[w_idx[c_CH_W-1:0]]) begin
                w_grant_ok = 1'b1;
                w_grant_ch = w_idx[c_CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_shift    = {r_rem, r_work[r_bit]};
        w_sub      = w_shift - c_RANGE;
        w_rem_next = (w_shift >= c_RANGE) ? w_sub[OUT_BITS-1:0] : w_shift[OUT_BITS-1:0];
        w_result   = c_MIN + r_rem;
        w_rr_next  = (r_ch == c_LAST) ? '0 : r_ch + 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_rr    <= '0;
            r_work  <= '0;
            r_rem   <= '0;
            r_bit   <= '0;
            r_valid <= '0;
            r_dout  <= {N_CH{c_MID}};
            r_busy  <= 1'b0;
        end else begin
            r_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_ok) begin
                        r_ch    <= w_grant_ch;
                        r_busy  <= 1'b1;
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_work  <= w_lfsr[OUT_BITS-1:0];
                    r_rem   <= '0;
                    r_bit   <= c_BIT_TOP;
                    r_state <= REDUCE;
                end
                REDUCE: begin
                    r_rem <= w_rem_next;
                    if (r_bit == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_bit <= r_bit - 1'b1;
                    end
                end
                DONE: begin
                    r_dout[r_ch*OUT_BITS +: OUT_BITS] <= w_result;
                    r_valid[r_ch] <= 1'b1;
                    r_rr          <= w_rr_next;
                    r_busy        <= 1'b0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid = r_valid;
    assign dout  = r_dout;
    assign busy  = r_busy;

endmodule
`default_nettype wire
